// File: rtl/coffee_dispenser_if.sv
`default_nettype none
// ============================================================================
//  Module      : coffee_dispenser_if
//  Description : Signal bundle between the vending controller and the coffee
//                dispenser.
//                master : vending controller side (drives request + sensor)
//                slave  : dispenser side (drives actuators and status)
//  Signals     : dispense, coffee_select[2:0], cup_present (master -> slave)
//                dispense_done, cup_drop, water_valve, flavour_valve[1:0],
//                busy, fault, select_err, cups_served[15:0] (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface coffee_dispenser_if;
    logic        dispense;
    logic [2:0]  coffee_select;
    logic        cup_present;

    logic        dispense_done;
    logic        cup_drop;
    logic        water_valve;
    logic [1:0]  flavour_valve;
    logic        busy;
    logic        fault;
    logic        select_err;
    logic [15:0] cups_served;

    modport master (
        output dispense, coffee_select, cup_present,
        input  dispense_done, cup_drop, water_valve, flavour_valve,
               busy, fault, select_err, cups_served
    );

    modport slave (
        input  dispense, coffee_select, cup_present,
        output dispense_done, cup_drop, water_valve, flavour_valve,
               busy, fault, select_err, cups_served
    );
endinterface
`default_nettype wire

// File: rtl/coffee_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : coffee_dispenser
//  Description : Drink sequencer. A valid request drops a cup, pours hot
//                water, optionally opens one flavour valve, then pulses
//                dispense_done and counts the drink. A missing cup locks the
//                machine in a sticky fault until reset.
//  Ports       : clk            - single rising-edge clock
//                reset          - synchronous active-high reset
//                bus (slave)    - request inputs, actuator and status outputs
//  Parameters  : CUP_CYCLES, POUR_CYCLES, FLAVOUR_CYCLES - phase lengths
//                (1..255 cycles each)
//  Revision    : 1.0 - initial release
// ============================================================================
module coffee_dispenser #(
    parameter int CUP_CYCLES     = 4,
    parameter int POUR_CYCLES    = 8,
    parameter int FLAVOUR_CYCLES = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    coffee_dispenser_if.slave  bus
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CUP     = 3'd1;
    localparam logic [2:0] c_POUR    = 3'd2;
    localparam logic [2:0] c_FLAVOUR = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;
    localparam logic [2:0] c_HOLD    = 3'd5;
    localparam logic [2:0] c_FAULT   = 3'd6;

    // Phase counters are loaded with length-1 and the phase ends at zero.
    localparam logic [7:0] c_CUP_LAST     = 8'(CUP_CYCLES - 1);
    localparam logic [7:0] c_POUR_LAST    = 8'(POUR_CYCLES - 1);
    localparam logic [7:0] c_FLAVOUR_LAST = 8'(FLAVOUR_CYCLES - 1);

    logic [2:0]  r_state_q, w_state_d;
    logic [7:0]  r_cnt_q,   w_cnt_d;
    logic [1:0]  r_sel_q,   w_sel_d;

    logic        r_done_q,  w_done_d;
    logic        r_cup_q,   w_cup_d;
    logic        r_water_q, w_water_d;
    logic [1:0]  r_flav_q,  w_flav_d;
    logic        r_busy_q,  w_busy_d;
    logic        r_fault_q, w_fault_d;
    logic        r_err_q,   w_err_d;
    logic [15:0] r_cups_q,  w_cups_d;

    logic        w_sel_valid;
    logic        w_bad_req;

    assign w_sel_valid = (bus.coffee_select >= 3'd1) && (bus.coffee_select <= 3'd3);
    // An invalid request is only recognised when idle; it is answered at once.
    assign w_bad_req   = (r_state_q == c_IDLE) && bus.dispense && !w_sel_valid;

    // ------------------------------------------------------------------
    // State register (also holds the registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= c_IDLE;
            r_cnt_q   <= 8'd0;
            r_sel_q   <= 2'd0;
            r_done_q  <= 1'b0;
            r_cup_q   <= 1'b0;
            r_water_q <= 1'b0;
            r_flav_q  <= 2'b00;
            r_busy_q  <= 1'b0;
            r_fault_q <= 1'b0;
            r_err_q   <= 1'b0;
            r_cups_q  <= 16'd0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_sel_q   <= w_sel_d;
            r_done_q  <= w_done_d;
            r_cup_q   <= w_cup_d;
            r_water_q <= w_water_d;
            r_flav_q  <= w_flav_d;
            r_busy_q  <= w_busy_d;
            r_fault_q <= w_fault_d;
            r_err_q   <= w_err_d;
            r_cups_q  <= w_cups_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_sel_d   = r_sel_q;
        case (r_state_q)
            c_IDLE: begin
                if (bus.dispense) begin
                    if (w_sel_valid) begin
                        w_state_d = c_CUP;
                        w_cnt_d   = c_CUP_LAST;
                        w_sel_d   = bus.coffee_select[1:0];
                    end else begin
                        w_state_d = c_HOLD;
                    end
                end
            end
            c_CUP: begin
                if (r_cnt_q == 8'd0) begin
                    // Cup sensor is only trusted on the last drop cycle.
                    if (bus.cup_present) begin
                        w_state_d = c_POUR;
                        w_cnt_d   = c_POUR_LAST;
                    end else begin
                        w_state_d = c_FAULT;
                    end
                end else begin
                    w_cnt_d = r_cnt_q - 8'd1;
                end
            end
            c_POUR: begin
                if (r_cnt_q == 8'd0) begin
                    if (r_sel_q == 2'd1) begin
                        w_state_d = c_DONE;
                    end else begin
                        w_state_d = c_FLAVOUR;
                        w_cnt_d   = c_FLAVOUR_LAST;
                    end
                end else begin
                    w_cnt_d = r_cnt_q - 8'd1;
                end
            end
            c_FLAVOUR: begin
                if (r_cnt_q == 8'd0) begin
                    w_state_d = c_DONE;
                end else begin
                    w_cnt_d = r_cnt_q - 8'd1;
                end
            end
            c_DONE: begin
                w_state_d = c_HOLD;
            end
            c_HOLD: begin
                // Wait for the controller to drop its level request so a
                // held-high dispense cannot start another drink.
                if (!bus.dispense) begin
                    w_state_d = c_IDLE;
                end
            end
            c_FAULT: begin
                w_state_d = c_FAULT;
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: actuators and done follow the current state into the
    // output flops, so each is high one cycle after the state that owns it.
    // busy/fault track the state being entered so they match the state.
    // ------------------------------------------------------------------
    always_comb begin
        w_cup_d   = (r_state_q == c_CUP);
        w_water_d = (r_state_q == c_POUR);
        w_flav_d  = 2'b00;
        if (r_state_q == c_FLAVOUR) begin
            w_flav_d = (r_sel_q == 2'd2) ? 2'b01 : 2'b10;
        end
        w_done_d  = (r_state_q == c_DONE) || w_bad_req;
        w_err_d   = w_bad_req;
        w_busy_d  = (w_state_d != c_IDLE);
        w_fault_d = (w_state_d == c_FAULT);
        w_cups_d  = r_cups_q;
        if ((r_state_q == c_DONE) && (r_cups_q != 16'hFFFF)) begin
            w_cups_d = r_cups_q + 16'd1;
        end
    end

    assign bus.dispense_done = r_done_q;
    assign bus.cup_drop      = r_cup_q;
    assign bus.water_valve   = r_water_q;
    assign bus.flavour_valve = r_flav_q;
    assign bus.busy          = r_busy_q;
    assign bus.fault         = r_fault_q;
    assign bus.select_err    = r_err_q;
    assign bus.cups_served   = r_cups_q;

endmodule
`default_nettype wire

// File: tb/tb_coffee_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coffee_dispenser
//  Description : Self-checking bench for coffee_dispenser. Each drink is
//                predicted as a timeline of output phases measured in clock
//                edges from the accepted request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coffee_dispenser;

    localparam int CUP  = 4;
    localparam int POUR = 8;
    localparam int FLAV = 3;

    logic clk = 1'b0;
    logic reset;

    coffee_dispenser_if bus ();

    coffee_dispenser #(
        .CUP_CYCLES     (CUP),
        .POUR_CYCLES    (POUR),
        .FLAVOUR_CYCLES (FLAV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_cups;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.dispense_done, bus.cup_drop, bus.water_valve, bus.flavour_valve,
                bus.busy, bus.fault, bus.select_err};
    endfunction

    function automatic logic [7:0] pack(input bit done, input bit cup, input bit water,
                                        input logic [1:0] flav, input bit busy,
                                        input bit fault, input bit err);
        return {done, cup, water, flav, busy, fault, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with random inputs present; reset must win over all of them.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset             = 1'b1;
            bus.dispense      = 1'($urandom);
            bus.coffee_select = 3'($urandom);
            bus.cup_present   = 1'($urandom);
            tick();
            check("reset_outs", 32'(outs()), 32'h0);
            check("reset_cups", 32'(bus.cups_served), 32'h0);
        end
        m_cups       = 16'd0;
        reset        = 1'b0;
        bus.dispense = 1'b0;
    endtask

    // One request starting at the next edge (edge 0). 'hold' is the number of
    // extra edges dispense stays high after the done edge, 'noise' wiggles
    // dispense/select mid-drink, 'abort_at' (>=0) asserts reset at that edge.
    task automatic drink(input logic [2:0] sel, input bit cup, input int hold,
                         input bit noise, input int abort_at);
        bit        valid;
        bit        flav;
        bit        nocup;
        bit        aborted;
        int        d;
        int        last;
        logic [1:0] fv;
        logic [7:0] e;
        valid   = (sel >= 3'd1) && (sel <= 3'd3);
        flav    = valid && (sel != 3'd1);
        nocup   = valid && !cup;
        aborted = 1'b0;
        fv      = (sel == 3'd2) ? 2'b01 : 2'b10;
        d       = valid ? (CUP + POUR + (flav ? FLAV : 0) + 1) : 0;
        last    = nocup ? 60 : d + hold + 2;

        bus.dispense      = 1'b1;
        bus.coffee_select = sel;
        bus.cup_present   = cup;

        for (int k = 0; k <= last; k++) begin
            if (k == abort_at) reset = 1'b1;
            tick();
            if (k == abort_at) begin
                m_cups = 16'd0;
                check($sformatf("abort_outs k=%0d", k), 32'(outs()), 32'h0);
                check($sformatf("abort_cups k=%0d", k), 32'(bus.cups_served), 32'h0);
                reset        = 1'b0;
                bus.dispense = 1'b0;
                aborted      = 1'b1;
                break;
            end

            if (nocup) begin
                e = pack(1'b0, (k >= 1 && k <= CUP), 1'b0, 2'b00, 1'b1, (k >= CUP), 1'b0);
            end else begin
                if (valid && k == d) m_cups = (m_cups == 16'hFFFF) ? m_cups : m_cups + 16'd1;
                e = pack(k == d,
                         valid && k >= 1 && k <= CUP,
                         valid && k >= CUP + 1 && k <= CUP + POUR,
                         (flav && k >= CUP + POUR + 1 && k <= CUP + POUR + FLAV) ? fv : 2'b00,
                         k <= d + hold,
                         1'b0,
                         !valid && k == 0);
            end
            check($sformatf("outs sel=%0d cup=%0d k=%0d", sel, cup, k), 32'(outs()), 32'(e));
            check($sformatf("cups sel=%0d k=%0d", sel, k), 32'(bus.cups_served), 32'(m_cups));

            // Inputs for edge k+1.
            if (nocup) begin
                bus.dispense      = 1'($urandom);
                bus.coffee_select = 3'($urandom);
            end else if (k + 1 <= d - 1) begin
                if (noise) begin
                    bus.dispense      = 1'($urandom);
                    bus.coffee_select = 3'($urandom);
                end
            end else if (k + 1 <= d + hold) begin
                bus.dispense      = 1'b1;
                bus.coffee_select = 3'($urandom_range(1, 3));
            end else begin
                bus.dispense      = 1'b0;
                bus.coffee_select = 3'($urandom);
            end
        end

        if (nocup && !aborted) do_reset(1);
    endtask

    initial begin
        reset             = 1'b1;
        bus.dispense      = 1'b0;
        bus.coffee_select = 3'd0;
        bus.cup_present   = 1'b0;
        m_cups            = 16'd0;

        do_reset(3);

        // Directed scenarios.
        drink(3'd1, 1'b1, 0, 1'b0, -1);   // plain
        drink(3'd3, 1'b1, 5, 1'b0, -1);   // coconut, dispense held 5 more
        drink(3'd2, 1'b1, 1, 1'b1, -1);   // hazelnut with mid-drink noise
        drink(3'd5, 1'b1, 2, 1'b0, -1);   // invalid code
        drink(3'd0, 1'b1, 0, 1'b0, -1);   // invalid code 0
        drink(3'd1, 1'b1, 0, 1'b0, 8);    // reset mid-pour
        drink(3'd1, 1'b1, 0, 1'b0, -1);   // completes after abort
        drink(3'd2, 1'b0, 0, 1'b0, -1);   // no cup -> fault, then reset
        do_reset(1);
        drink(3'd1, 1'b1, 0, 1'b0, -1);   // accepted on first cycle after reset

        // Randomized scenarios.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] s;
            bit         c;
            int         h;
            bit         nz;
            int         ab;
            s  = 3'($urandom_range(0, 7));
            c  = ($urandom_range(0, 7) != 0);
            h  = int'($urandom_range(0, 4));
            nz = 1'($urandom);
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : -1;
            drink(s, c, h, nz, ab);
        end

        // Saturation: preload the counter one below full.
        bus.dispense = 1'b0;
        force dut.r_cups_q = 16'hFFFE;
        tick();
        tick();
        release dut.r_cups_q;
        m_cups = 16'hFFFE;
        tick();
        check("preload_cups", 32'(bus.cups_served), 32'hFFFE);
        drink(3'd1, 1'b1, 0, 1'b0, -1);   // -> FFFF
        drink(3'd2, 1'b1, 0, 1'b0, -1);   // stays FFFF
        check("saturated_cups", 32'(bus.cups_served), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coffee_dispenser.md
COFFEE_DISPENSER -- requirements
Module: coffee_dispenser

Interface
REQ-001 Parameter CUP_CYCLES, default 4, cycles cup_drop is held (1..255).
REQ-002 Parameter POUR_CYCLES, default 8, cycles water_valve is held (1..255).
REQ-003 Parameter FLAVOUR_CYCLES, default 3, cycles a flavour valve is held (1..255).
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 dispense  in  1  level request from the vending controller; held high until dispense_done is seen.
REQ-007 coffee_select  in  3  drink code: 1 plain, 2 hazelnut, 3 coconut; all other codes invalid.
REQ-008 cup_present  in  1  cup sensor, high when a cup sits under the spout.
REQ-009 dispense_done  out  1  one-cycle pulse when a drink is complete.
REQ-010 cup_drop  out  1  cup release actuator.
REQ-011 water_valve  out  1  hot water valve.
REQ-012 flavour_valve  out  2  01 hazelnut, 10 coconut, 00 closed; 11 SHALL never be driven.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 fault  out  1  sticky no-cup fault.
REQ-015 select_err  out  1  one-cycle pulse on invalid coffee_select.
REQ-016 cups_served  out  16  count of completed drinks.

Function
REQ-017 All outputs SHALL be registered; states: IDLE, CUP, POUR, FLAVOUR, DONE, HOLD, FAULT.
REQ-018 IDLE, dispense=1, select in {1,2,3}: latch select, enter CUP next cycle; dispense=0: remain IDLE.
REQ-019 IDLE, dispense=1, invalid select: select_err=1 and dispense_done=1 for one cycle, no actuator driven, go HOLD, cups_served unchanged.
REQ-020 CUP: cup_drop=1 for exactly CUP_CYCLES cycles; on last CUP cycle cup_present sampled: 1 -> POUR, 0 -> FAULT.
REQ-021 POUR: water_valve=1 for exactly POUR_CYCLES cycles; then latched select 1 -> DONE, 2 or 3 -> FLAVOUR.
REQ-022 FLAVOUR: flavour_valve=01 (select 2) or 10 (select 3) for exactly FLAVOUR_CYCLES cycles, then DONE.
REQ-023 DONE: dispense_done=1 for exactly one cycle, cups_served incremented by 1, saturating at 16'hFFFF; then HOLD.
REQ-024 HOLD: remain until dispense=0 is sampled, then IDLE; a held-high dispense SHALL NOT start a second drink.
REQ-025 FAULT: fault=1, all actuators 0, dispense_done never pulsed, dispense ignored; exit only via reset.
REQ-026 dispense falling or coffee_select changing mid-drink (CUP/POUR/FLAVOUR) SHALL be ignored; sequence completes with latched select.
REQ-027 Actuators mutually exclusive: at most one of cup_drop, water_valve, flavour_valve nonzero in any cycle.
REQ-028 Latency with defaults, request sampled at edge 0: plain dispense_done high after edge 13, hazelnut/coconut after edge 16.
REQ-029 Phase counters SHALL be 8 bits and reload on every phase entry; no wrap-around observable.

Reset
REQ-030 reset=1 at any edge, including mid-drink or in FAULT: state IDLE, all outputs 0, cups_served 0, fault cleared, latched select cleared.
REQ-031 reset SHALL take priority over every other input in the same cycle.
REQ-032 First cycle after reset release SHALL accept a request if dispense=1.

Verification
REQ-033 Plain: dispense=1, select=1, cup_present=1 -> cup_drop cycles 1-4, water_valve 5-12, dispense_done pulse cycle 13, cups_served=1.
REQ-034 Coconut: select=3 -> flavour_valve=10 cycles 13-15, done cycle 16; dispense held high 5 more cycles -> no restart, busy=1 until dispense=0.
REQ-035 No cup: select=2, cup_present=0 -> fault=1 after cycle 4, no water, no dispense_done for 50 cycles; reset clears fault.
REQ-036 Invalid: select=5, dispense=1 -> select_err and dispense_done pulse next cycle, all actuators 0, cups_served unchanged.
REQ-037 Reset mid-POUR (cycle 8): water_valve=0 next cycle, busy=0, cups_served=0; new plain request completes normally.
REQ-038 Saturation: preload via 65535 plain drinks (or forced) -> further drink leaves cups_served=16'hFFFF.
